ysyx_24110006_axi_arbiter: RTL and testbench

YSYX_24110006_AXI_ARBITER -- requirements
Module: ysyx_24110006_axi_arbiter

---
 rtl/ysyx_24110006_axi_pkg.sv | 19 +
 rtl/ysyx_24110006_axi_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_24110006_axi_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared encodings for the IFU/LSU AXI arbiter: FSM states, grant codes and
// the AXI burst/size constants used by its masters.
package ysyx_24110006_axi_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IFU_RD = 3'd1;
    localparam logic [2:0] ST_LSU_RD = 3'd2;
    localparam logic [2:0] ST_LSU_WR = 3'd3;
    localparam logic [2:0] ST_LSU_B  = 3'd4;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI arbiter.
// One transaction at a time; the grant is registered out of IDLE.
module ysyx_24110006_axi_arbiter
    import ysyx_24110006_axi_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // IFU read channels
    input  logic [31:0] i_ifu_araddr,
    input  logic        i_ifu_arvalid,
    input  logic [3:0]  i_ifu_arid,
    input  logic [7:0]  i_ifu_arlen,
    input  logic [2:0]  i_ifu_arsize,
    input  logic [1:0]  i_ifu_arburst,
    output logic        o_ifu_arready,
    output logic [31:0] o_ifu_rdata,
    output logic [1:0]  o_ifu_rresp,
    output logic [3:0]  o_ifu_rid,
    output logic        o_ifu_rlast,
    output logic        o_ifu_rvalid,
    input  logic        i_ifu_rready,
    // LSU read channels
    input  logic [31:0] i_lsu_araddr,
    input  logic        i_lsu_arvalid,
    input  logic [3:0]  i_lsu_arid,
    input  logic [7:0]  i_lsu_arlen,
    input  logic [2:0]  i_lsu_arsize,
    input  logic [1:0]  i_lsu_arburst,
    output logic        o_lsu_arready,
    output logic [31:0] o_lsu_rdata,
    output logic [1:0]  o_lsu_rresp,
    output logic [3:0]  o_lsu_rid,
    output logic        o_lsu_rlast,
    output logic        o_lsu_rvalid,
    input  logic        i_lsu_rready,
    // LSU write channels
    input  logic [31:0] i_lsu_awaddr,
    input  logic        i_lsu_awvalid,
    input  logic [3:0]  i_lsu_awid,
    input  logic [7:0]  i_lsu_awlen,
    input  logic [2:0]  i_lsu_awsize,
    input  logic [1:0]  i_lsu_awburst,
    output logic        o_lsu_awready,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_wstrb,
    input  logic        i_lsu_wlast,
    input  logic        i_lsu_wvalid,
    output logic        o_lsu_wready,
    output logic [1:0]  o_lsu_bresp,
    output logic [3:0]  o_lsu_bid,
    output logic        o_lsu_bvalid,
    input  logic        i_lsu_bready,
    // Slave-side channels toward memory
    output logic [31:0] o_axi_araddr,
    output logic        o_axi_arvalid,
    output logic [3:0]  o_axi_arid,
    output logic [7:0]  o_axi_arlen,
    output logic [2:0]  o_axi_arsize,
    output logic [1:0]  o_axi_arburst,
    input  logic        i_axi_arready,
    input  logic [31:0] i_axi_rdata,
    input  logic [1:0]  i_axi_rresp,
    input  logic [3:0]  i_axi_rid,
    input  logic        i_axi_rlast,
    input  logic        i_axi_rvalid,
    output logic        o_axi_rready,
    output logic [31:0] o_axi_awaddr,
    output logic        o_axi_awvalid,
    output logic [3:0]  o_axi_awid,
    output logic [7:0]  o_axi_awlen,
    output logic [2:0]  o_axi_awsize,
    output logic [1:0]  o_axi_awburst,
    input  logic        i_axi_awready,
    output logic [31:0] o_axi_wdata,
    output logic [3:0]  o_axi_wstrb,
    output logic        o_axi_wlast,
    output logic        o_axi_wvalid,
    input  logic        i_axi_wready,
    input  logic [1:0]  i_axi_bresp,
    input  logic [3:0]  i_axi_bid,
    input  logic        i_axi_bvalid,
    output logic        o_axi_bready,
    output logic [1:0]  o_grant
);

    logic [2:0] state_q, state_d;
    logic       last_lsu_q, last_lsu_d;   // 1: LSU held the most recent grant
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic lsu_req, lsu_wins, aw_hs, w_hs, r_end, b_end;

    assign lsu_req  = i_lsu_awvalid | i_lsu_arvalid;
    assign lsu_wins = lsu_req & (~i_ifu_arvalid | (RR_EN == 0) | ~last_lsu_q);
    assign aw_hs    = o_axi_awvalid & i_axi_awready;
    assign w_hs     = o_axi_wvalid & i_axi_wready;
    assign r_end    = i_axi_rvalid & o_axi_rready & i_axi_rlast;
    assign b_end    = i_axi_bvalid & o_axi_bready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            last_lsu_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_wins) begin
                    state_d    = i_lsu_awvalid ? ST_LSU_WR : ST_LSU_RD;
                    last_lsu_d = 1'b1;
                end else if (i_ifu_arvalid) begin
                    state_d    = ST_IFU_RD;
                    last_lsu_d = 1'b0;
                end
            end
            ST_IFU_RD, ST_LSU_RD: if (r_end) state_d = ST_IDLE;
            ST_LSU_WR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_LSU_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_LSU_B: if (b_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload fields are muxed freely; only valid/ready carry the grant.
    always_comb begin
        o_axi_araddr  = (state_q == ST_LSU_RD) ? i_lsu_araddr  : i_ifu_araddr;
        o_axi_arid    = (state_q == ST_LSU_RD) ? i_lsu_arid    : i_ifu_arid;
        o_axi_arlen   = (state_q == ST_LSU_RD) ? i_lsu_arlen   : i_ifu_arlen;
        o_axi_arsize  = (state_q == ST_LSU_RD) ? i_lsu_arsize  : i_ifu_arsize;
        o_axi_arburst = (state_q == ST_LSU_RD) ? i_lsu_arburst : i_ifu_arburst;
        o_axi_awaddr  = i_lsu_awaddr;
        o_axi_awid    = i_lsu_awid;
        o_axi_awlen   = i_lsu_awlen;
        o_axi_awsize  = i_lsu_awsize;
        o_axi_awburst = i_lsu_awburst;
        o_axi_wdata   = i_lsu_wdata;
        o_axi_wstrb   = i_lsu_wstrb;
        o_axi_wlast   = i_lsu_wlast;
        o_ifu_rdata   = i_axi_rdata;
        o_ifu_rresp   = i_axi_rresp;
        o_ifu_rid     = i_axi_rid;
        o_ifu_rlast   = i_axi_rlast;
        o_lsu_rdata   = i_axi_rdata;
        o_lsu_rresp   = i_axi_rresp;
        o_lsu_rid     = i_axi_rid;
        o_lsu_rlast   = i_axi_rlast;
        o_lsu_bresp   = i_axi_bresp;
        o_lsu_bid     = i_axi_bid;
        o_axi_arvalid = 1'b0;
        o_axi_rready  = 1'b0;
        o_axi_awvalid = 1'b0;
        o_axi_wvalid  = 1'b0;
        o_axi_bready  = 1'b0;
        o_ifu_arready = 1'b0;
        o_ifu_rvalid  = 1'b0;
        o_lsu_arready = 1'b0;
        o_lsu_rvalid  = 1'b0;
        o_lsu_awready = 1'b0;
        o_lsu_wready  = 1'b0;
        o_lsu_bvalid  = 1'b0;
        o_grant       = GRANT_NONE;
        case (state_q)
            ST_IFU_RD: begin
                o_grant       = GRANT_IFU;
                o_axi_arvalid = i_ifu_arvalid;
                o_axi_rready  = i_ifu_rready;
                o_ifu_arready = i_axi_arready;
                o_ifu_rvalid  = i_axi_rvalid;
            end
            ST_LSU_RD: begin
                o_grant       = GRANT_LSU;
                o_axi_arvalid = i_lsu_arvalid;
                o_axi_rready  = i_lsu_rready;
                o_lsu_arready = i_axi_arready;
                o_lsu_rvalid  = i_axi_rvalid;
            end
            ST_LSU_WR: begin
                o_grant       = GRANT_LSU;
                o_axi_awvalid = i_lsu_awvalid & ~aw_done_q;
                o_lsu_awready = i_axi_awready & ~aw_done_q;
                o_axi_wvalid  = i_lsu_wvalid & ~w_done_q;
                o_lsu_wready  = i_axi_wready & ~w_done_q;
            end
            ST_LSU_B: begin
                o_grant       = GRANT_LSU;
                o_axi_bready  = i_lsu_bready;
                o_lsu_bvalid  = i_axi_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: a round-robin instance and a
// fixed-LSU-priority instance share one set of stimulus.
module tb_ysyx_24110006_axi_arbiter;
    import ysyx_24110006_axi_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_ifu_araddr, i_lsu_araddr, i_lsu_awaddr, i_lsu_wdata, i_axi_rdata;
    logic        i_ifu_arvalid, i_ifu_rready, i_lsu_arvalid, i_lsu_rready;
    logic        i_lsu_awvalid, i_lsu_wlast, i_lsu_wvalid, i_lsu_bready;
    logic [3:0]  i_ifu_arid, i_lsu_arid, i_lsu_awid, i_lsu_wstrb, i_axi_rid, i_axi_bid;
    logic [7:0]  i_ifu_arlen, i_lsu_arlen, i_lsu_awlen;
    logic [2:0]  i_ifu_arsize, i_lsu_arsize, i_lsu_awsize;
    logic [1:0]  i_ifu_arburst, i_lsu_arburst, i_lsu_awburst, i_axi_rresp, i_axi_bresp;
    logic        i_axi_arready, i_axi_rlast, i_axi_rvalid, i_axi_awready, i_axi_wready, i_axi_bvalid;

    logic m_ifu_arready, m_ifu_rlast, m_ifu_rvalid;
    logic [31:0] m_ifu_rdata; logic [1:0] m_ifu_rresp; logic [3:0] m_ifu_rid;
    logic m_lsu_arready, m_lsu_rlast, m_lsu_rvalid;
    logic [31:0] m_lsu_rdata; logic [1:0] m_lsu_rresp; logic [3:0] m_lsu_rid;
    logic m_lsu_awready, m_lsu_wready, m_lsu_bvalid;
    logic [1:0] m_lsu_bresp; logic [3:0] m_lsu_bid;
    logic [31:0] m_axi_araddr; logic m_axi_arvalid, m_axi_rready; logic [3:0] m_axi_arid;
    logic [7:0] m_axi_arlen; logic [2:0] m_axi_arsize; logic [1:0] m_axi_arburst;
    logic [31:0] m_axi_awaddr; logic m_axi_awvalid; logic [3:0] m_axi_awid;
    logic [7:0] m_axi_awlen; logic [2:0] m_axi_awsize; logic [1:0] m_axi_awburst;
    logic [31:0] m_axi_wdata; logic [3:0] m_axi_wstrb; logic m_axi_wlast, m_axi_wvalid;
    logic m_axi_bready; logic [1:0] m_grant;

    logic z_ifu_arready, z_ifu_rlast, z_ifu_rvalid;
    logic [31:0] z_ifu_rdata; logic [1:0] z_ifu_rresp; logic [3:0] z_ifu_rid;
    logic z_lsu_arready, z_lsu_rlast, z_lsu_rvalid;
    logic [31:0] z_lsu_rdata; logic [1:0] z_lsu_rresp; logic [3:0] z_lsu_rid;
    logic z_lsu_awready, z_lsu_wready, z_lsu_bvalid;
    logic [1:0] z_lsu_bresp; logic [3:0] z_lsu_bid;
    logic [31:0] z_axi_araddr; logic z_axi_arvalid, z_axi_rready; logic [3:0] z_axi_arid;
    logic [7:0] z_axi_arlen; logic [2:0] z_axi_arsize; logic [1:0] z_axi_arburst;
    logic [31:0] z_axi_awaddr; logic z_axi_awvalid; logic [3:0] z_axi_awid;
    logic [7:0] z_axi_awlen; logic [2:0] z_axi_awsize; logic [1:0] z_axi_awburst;
    logic [31:0] z_axi_wdata; logic [3:0] z_axi_wstrb; logic z_axi_wlast, z_axi_wvalid;
    logic z_axi_bready; logic [1:0] z_grant;

    ysyx_24110006_axi_arbiter #(.RR_EN(1)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_ifu_araddr(i_ifu_araddr), .i_ifu_arvalid(i_ifu_arvalid), .i_ifu_arid(i_ifu_arid),
        .i_ifu_arlen(i_ifu_arlen), .i_ifu_arsize(i_ifu_arsize), .i_ifu_arburst(i_ifu_arburst),
        .o_ifu_arready(m_ifu_arready), .o_ifu_rdata(m_ifu_rdata), .o_ifu_rresp(m_ifu_rresp),
        .o_ifu_rid(m_ifu_rid), .o_ifu_rlast(m_ifu_rlast), .o_ifu_rvalid(m_ifu_rvalid),
        .i_ifu_rready(i_ifu_rready),
        .i_lsu_araddr(i_lsu_araddr), .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_arid(i_lsu_arid),
        .i_lsu_arlen(i_lsu_arlen), .i_lsu_arsize(i_lsu_arsize), .i_lsu_arburst(i_lsu_arburst),
        .o_lsu_arready(m_lsu_arready), .o_lsu_rdata(m_lsu_rdata), .o_lsu_rresp(m_lsu_rresp),
        .o_lsu_rid(m_lsu_rid), .o_lsu_rlast(m_lsu_rlast), .o_lsu_rvalid(m_lsu_rvalid),
        .i_lsu_rready(i_lsu_rready),
        .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_awid(i_lsu_awid),
        .i_lsu_awlen(i_lsu_awlen), .i_lsu_awsize(i_lsu_awsize), .i_lsu_awburst(i_lsu_awburst),
        .o_lsu_awready(m_lsu_awready), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
        .i_lsu_wlast(i_lsu_wlast), .i_lsu_wvalid(i_lsu_wvalid), .o_lsu_wready(m_lsu_wready),
        .o_lsu_bresp(m_lsu_bresp), .o_lsu_bid(m_lsu_bid), .o_lsu_bvalid(m_lsu_bvalid),
        .i_lsu_bready(i_lsu_bready),
        .o_axi_araddr(m_axi_araddr), .o_axi_arvalid(m_axi_arvalid), .o_axi_arid(m_axi_arid),
        .o_axi_arlen(m_axi_arlen), .o_axi_arsize(m_axi_arsize), .o_axi_arburst(m_axi_arburst),
        .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
        .i_axi_rid(i_axi_rid), .i_axi_rlast(i_axi_rlast), .i_axi_rvalid(i_axi_rvalid),
        .o_axi_rready(m_axi_rready),
        .o_axi_awaddr(m_axi_awaddr), .o_axi_awvalid(m_axi_awvalid), .o_axi_awid(m_axi_awid),
        .o_axi_awlen(m_axi_awlen), .o_axi_awsize(m_axi_awsize), .o_axi_awburst(m_axi_awburst),
        .i_axi_awready(i_axi_awready),
        .o_axi_wdata(m_axi_wdata), .o_axi_wstrb(m_axi_wstrb), .o_axi_wlast(m_axi_wlast),
        .o_axi_wvalid(m_axi_wvalid), .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bid(i_axi_bid), .i_axi_bvalid(i_axi_bvalid),
        .o_axi_bready(m_axi_bready), .o_grant(m_grant)
    );

    ysyx_24110006_axi_arbiter #(.RR_EN(0)) dut_fp (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_ifu_araddr(i_ifu_araddr), .i_ifu_arvalid(i_ifu_arvalid), .i_ifu_arid(i_ifu_arid),
        .i_ifu_arlen(i_ifu_arlen), .i_ifu_arsize(i_ifu_arsize), .i_ifu_arburst(i_ifu_arburst),
        .o_ifu_arready(z_ifu_arready), .o_ifu_rdata(z_ifu_rdata), .o_ifu_rresp(z_ifu_rresp),
        .o_ifu_rid(z_ifu_rid), .o_ifu_rlast(z_ifu_rlast), .o_ifu_rvalid(z_ifu_rvalid),
        .i_ifu_rready(i_ifu_rready),
        .i_lsu_araddr(i_lsu_araddr), .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_arid(i_lsu_arid),
        .i_lsu_arlen(i_lsu_arlen), .i_lsu_arsize(i_lsu_arsize), .i_lsu_arburst(i_lsu_arburst),
        .o_lsu_arready(z_lsu_arready), .o_lsu_rdata(z_lsu_rdata), .o_lsu_rresp(z_lsu_rresp),
        .o_lsu_rid(z_lsu_rid), .o_lsu_rlast(z_lsu_rlast), .o_lsu_rvalid(z_lsu_rvalid),
        .i_lsu_rready(i_lsu_rready),
        .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_awid(i_lsu_awid),
        .i_lsu_awlen(i_lsu_awlen), .i_lsu_awsize(i_lsu_awsize), .i_lsu_awburst(i_lsu_awburst),
        .o_lsu_awready(z_lsu_awready), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
        .i_lsu_wlast(i_lsu_wlast), .i_lsu_wvalid(i_lsu_wvalid), .o_lsu_wready(z_lsu_wready),
        .o_lsu_bresp(z_lsu_bresp), .o_lsu_bid(z_lsu_bid), .o_lsu_bvalid(z_lsu_bvalid),
        .i_lsu_bready(i_lsu_bready),
        .o_axi_araddr(z_axi_araddr), .o_axi_arvalid(z_axi_arvalid), .o_axi_arid(z_axi_arid),
        .o_axi_arlen(z_axi_arlen), .o_axi_arsize(z_axi_arsize), .o_axi_arburst(z_axi_arburst),
        .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
        .i_axi_rid(i_axi_rid), .i_axi_rlast(i_axi_rlast), .i_axi_rvalid(i_axi_rvalid),
        .o_axi_rready(z_axi_rready),
        .o_axi_awaddr(z_axi_awaddr), .o_axi_awvalid(z_axi_awvalid), .o_axi_awid(z_axi_awid),
        .o_axi_awlen(z_axi_awlen), .o_axi_awsize(z_axi_awsize), .o_axi_awburst(z_axi_awburst),
        .i_axi_awready(i_axi_awready),
        .o_axi_wdata(z_axi_wdata), .o_axi_wstrb(z_axi_wstrb), .o_axi_wlast(z_axi_wlast),
        .o_axi_wvalid(z_axi_wvalid), .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bid(i_axi_bid), .i_axi_bvalid(i_axi_bvalid),
        .o_axi_bready(z_axi_bready), .o_grant(z_grant)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic chk1(input string nm, input logic act, input logic exp);
        chk32(nm, {31'b0, act}, {31'b0, exp});
    endtask
    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        chk32(nm, {30'b0, act}, {30'b0, exp});
    endtask

    task automatic nxt();
        @(negedge i_clock);
    endtask
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_ifu_araddr = '0; i_ifu_arvalid = 0; i_ifu_arid = '0; i_ifu_arlen = '0;
        i_ifu_arsize = SIZE_4B; i_ifu_arburst = BURST_INCR; i_ifu_rready = 1;
        i_lsu_araddr = '0; i_lsu_arvalid = 0; i_lsu_arid = '0; i_lsu_arlen = '0;
        i_lsu_arsize = SIZE_4B; i_lsu_arburst = BURST_FIXED; i_lsu_rready = 1;
        i_lsu_awaddr = '0; i_lsu_awvalid = 0; i_lsu_awid = '0; i_lsu_awlen = '0;
        i_lsu_awsize = SIZE_4B; i_lsu_awburst = BURST_FIXED;
        i_lsu_wdata = '0; i_lsu_wstrb = '0; i_lsu_wlast = 0; i_lsu_wvalid = 0; i_lsu_bready = 1;
        i_axi_arready = 0; i_axi_rdata = '0; i_axi_rresp = '0; i_axi_rid = '0;
        i_axi_rlast = 0; i_axi_rvalid = 0; i_axi_awready = 0; i_axi_wready = 0;
        i_axi_bresp = '0; i_axi_bid = '0; i_axi_bvalid = 0;
    endtask

    task automatic do_reset();
        nxt(); i_reset = 1; clear_inputs();
        nxt(); nxt(); i_reset = 0;
    endtask

    typedef struct packed {
        logic       ifu_arv, lsu_arv, ard, rv, rl;
        logic [1:0] g, g0;
        logic       axi_arv, ifu_ard, lsu_ard, ifu_rv, lsu_rv;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1;
        clear_inputs();
        do_reset();

        // Reset state
        settle();
        chk2("rst_grant", m_grant, GRANT_NONE);
        chk1("rst_axi_arvalid", m_axi_arvalid, 0);
        chk1("rst_axi_awvalid", m_axi_awvalid, 0);
        chk1("rst_axi_wvalid", m_axi_wvalid, 0);
        chk1("rst_axi_rready", m_axi_rready, 0);
        chk1("rst_lsu_bvalid", m_lsu_bvalid, 0);

        // IFU-only two-beat burst
        i_ifu_arvalid = 1; i_ifu_araddr = 32'h3000_0000; i_ifu_arlen = 8'd1;
        settle();
        chk2("ifu_g_idle", m_grant, GRANT_NONE);
        chk1("ifu_arv_idle", m_axi_arvalid, 0);
        nxt(); i_axi_arready = 1; settle();
        chk2("ifu_g_rd", m_grant, GRANT_IFU);
        chk1("ifu_axi_arvalid", m_axi_arvalid, 1);
        chk32("ifu_axi_araddr", m_axi_araddr, 32'h3000_0000);
        chk32("ifu_axi_arlen", {24'b0, m_axi_arlen}, 32'd1);
        chk2("ifu_axi_arburst", m_axi_arburst, BURST_INCR);
        chk1("ifu_arready", m_ifu_arready, 1);
        chk1("ifu_lsu_arready", m_lsu_arready, 0);
        nxt(); i_ifu_arvalid = 0; i_axi_arready = 0;
        i_axi_rvalid = 1; i_axi_rdata = 32'h11; i_axi_rlast = 0; settle();
        chk1("ifu_b1_rvalid", m_ifu_rvalid, 1);
        chk32("ifu_b1_rdata", m_ifu_rdata, 32'h11);
        chk1("ifu_b1_lsu_rvalid", m_lsu_rvalid, 0);
        chk1("ifu_b1_rready", m_axi_rready, 1);
        nxt(); i_axi_rdata = 32'h22; i_axi_rlast = 1; settle();
        chk1("ifu_b2_rvalid", m_ifu_rvalid, 1);
        chk32("ifu_b2_rdata", m_ifu_rdata, 32'h22);
        chk1("ifu_b2_rlast", m_ifu_rlast, 1);
        chk1("ifu_b2_lsu_rvalid", m_lsu_rvalid, 0);
        nxt(); i_axi_rvalid = 0; i_axi_rlast = 0; settle();
        chk2("ifu_g_done", m_grant, GRANT_NONE);

        // Tie-break table: both masters request continuously, slave ends each read in one beat
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i != 0) nxt();
            i_ifu_arvalid = tbl[i].ifu_arv; i_lsu_arvalid = tbl[i].lsu_arv;
            i_axi_arready = tbl[i].ard; i_axi_rvalid = tbl[i].rv; i_axi_rlast = tbl[i].rl;
            settle();
            chk2($sformatf("tie%0d_grant_rr", i), m_grant, tbl[i].g);
            chk2($sformatf("tie%0d_grant_fixed", i), z_grant, tbl[i].g0);
            chk1($sformatf("tie%0d_axi_arvalid", i), m_axi_arvalid, tbl[i].axi_arv);
            chk1($sformatf("tie%0d_ifu_arready", i), m_ifu_arready, tbl[i].ifu_ard);
            chk1($sformatf("tie%0d_lsu_arready", i), m_lsu_arready, tbl[i].lsu_ard);
            chk1($sformatf("tie%0d_ifu_rvalid", i), m_ifu_rvalid, tbl[i].ifu_rv);
            chk1($sformatf("tie%0d_lsu_rvalid", i), m_lsu_rvalid, tbl[i].lsu_rv);
        end

        // LSU single-beat write, awready two cycles ahead of wready
        nxt(); i_lsu_awvalid = 1; i_lsu_awaddr = 32'h8000_0010; i_lsu_awlen = 0;
        i_lsu_wvalid = 1; i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_wstrb = 4'hF; i_lsu_wlast = 1;
        settle();
        chk2("wr_g_idle", m_grant, GRANT_NONE);
        chk1("wr_awv_idle", m_axi_awvalid, 0);
        nxt(); i_axi_awready = 1; settle();
        chk2("wr_g", m_grant, GRANT_LSU);
        chk1("wr_axi_awvalid", m_axi_awvalid, 1);
        chk32("wr_axi_awaddr", m_axi_awaddr, 32'h8000_0010);
        chk1("wr_axi_wvalid", m_axi_wvalid, 1);
        chk32("wr_axi_wdata", m_axi_wdata, 32'hDEAD_BEEF);
        chk32("wr_axi_wstrb", {28'b0, m_axi_wstrb}, 32'hF);
        chk1("wr_axi_wlast", m_axi_wlast, 1);
        chk1("wr_lsu_awready", m_lsu_awready, 1);
        chk1("wr_lsu_wready", m_lsu_wready, 0);
        nxt(); settle();
        chk1("wr_aw_once_valid", m_axi_awvalid, 0);
        chk1("wr_aw_once_ready", m_lsu_awready, 0);
        chk1("wr_w_pending", m_axi_wvalid, 1);
        nxt(); i_lsu_awvalid = 0; i_axi_awready = 0; i_axi_wready = 1; settle();
        chk1("wr_lsu_wready2", m_lsu_wready, 1);
        chk2("wr_g2", m_grant, GRANT_LSU);
        chk2("wr_g2_fixed", z_grant, GRANT_LSU);
        nxt(); i_lsu_wvalid = 0; i_axi_wready = 0; i_axi_bvalid = 1; i_axi_bresp = 2'b00; settle();
        chk1("wr_b_bvalid", m_lsu_bvalid, 1);
        chk2("wr_b_bresp", m_lsu_bresp, 2'b00);
        chk1("wr_b_bready", m_axi_bready, 1);
        chk1("wr_b_wvalid", m_axi_wvalid, 0);
        chk2("wr_b_grant", m_grant, GRANT_LSU);
        nxt(); i_axi_bvalid = 0; settle();
        chk2("wr_done_grant", m_grant, GRANT_NONE);
        chk1("wr_done_bvalid", m_lsu_bvalid, 0);

        // LSU aw+ar together: write first (same-cycle aw/w handshakes), then the held read
        nxt(); i_lsu_arvalid = 1; i_lsu_araddr = 32'h8000_0100;
        i_lsu_awvalid = 1; i_lsu_wvalid = 1; i_lsu_wdata = 32'h1234_5678; settle();
        chk2("awar_g_idle", m_grant, GRANT_NONE);
        nxt(); i_axi_awready = 1; i_axi_wready = 1; settle();
        chk1("awar_axi_awvalid", m_axi_awvalid, 1);
        chk1("awar_axi_wvalid", m_axi_wvalid, 1);
        chk1("awar_axi_arvalid", m_axi_arvalid, 0);
        chk1("awar_lsu_arready", m_lsu_arready, 0);
        nxt(); i_lsu_awvalid = 0; i_lsu_wvalid = 0; i_axi_awready = 0; i_axi_wready = 0;
        i_axi_bvalid = 1; i_axi_bresp = 2'b10; settle();
        chk1("awar_bvalid", m_lsu_bvalid, 1);
        chk2("awar_bresp_err", m_lsu_bresp, 2'b10);
        chk1("awar_b_arvalid", m_axi_arvalid, 0);
        nxt(); i_axi_bvalid = 0; i_axi_bresp = 0; settle();
        chk2("awar_g_gap", m_grant, GRANT_NONE);
        nxt(); i_axi_arready = 1; settle();
        chk2("awar_g_rd", m_grant, GRANT_LSU);
        chk1("awar_rd_arvalid", m_axi_arvalid, 1);
        chk32("awar_rd_araddr", m_axi_araddr, 32'h8000_0100);
        chk1("awar_rd_arready", m_lsu_arready, 1);
        nxt(); i_lsu_arvalid = 0; i_axi_arready = 0;
        i_axi_rvalid = 1; i_axi_rlast = 1; i_axi_rdata = 32'h55; settle();
        chk1("awar_lsu_rvalid", m_lsu_rvalid, 1);
        chk32("awar_lsu_rdata", m_lsu_rdata, 32'h55);
        chk1("awar_ifu_rvalid", m_ifu_rvalid, 0);
        nxt(); i_axi_rvalid = 0; i_axi_rlast = 0; settle();
        chk2("awar_g_done", m_grant, GRANT_NONE);

        // Reset after beat 1 of a four-beat IFU burst, then a fresh IFU read
        nxt(); i_ifu_arvalid = 1; i_ifu_araddr = 32'h3000_0020; i_ifu_arlen = 8'd3;
        nxt(); i_axi_arready = 1; settle();
        chk2("mid_g", m_grant, GRANT_IFU);
        nxt(); i_ifu_arvalid = 0; i_axi_arready = 0;
        i_axi_rvalid = 1; i_axi_rdata = 32'hA1; settle();
        chk1("mid_b1_rvalid", m_ifu_rvalid, 1);
        nxt(); i_reset = 1;
        nxt(); i_reset = 0; settle();
        chk2("mid_rst_grant", m_grant, GRANT_NONE);
        chk1("mid_rst_ifu_rvalid", m_ifu_rvalid, 0);
        chk1("mid_rst_rready", m_axi_rready, 0);
        chk1("mid_rst_arvalid", m_axi_arvalid, 0);
        nxt(); i_axi_rvalid = 0; i_ifu_arvalid = 1; i_ifu_araddr = 32'h3000_0040; i_ifu_arlen = 0;
        nxt(); i_axi_arready = 1; settle();
        chk2("fresh_g", m_grant, GRANT_IFU);
        chk32("fresh_araddr", m_axi_araddr, 32'h3000_0040);
        nxt(); i_ifu_arvalid = 0; i_axi_arready = 0;
        i_axi_rvalid = 1; i_axi_rlast = 1; i_axi_rdata = 32'hB2; settle();
        chk1("fresh_rvalid", m_ifu_rvalid, 1);
        chk32("fresh_rdata", m_ifu_rdata, 32'hB2);
        nxt(); i_axi_rvalid = 0; i_axi_rlast = 0; settle();
        chk2("fresh_g_done", m_grant, GRANT_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
